// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port synchronous RAM with
// registered read data. Commands (read/write, start address, word count) arrive
// over a valid/ready handshake. Write words stream in, read words stream out.
// Optional build macro RAM_BOUNDS_CHECK_EN: commands whose address range runs
// past MEM_SIZE are accepted, then rejected with an err/done pulse and no RAM access.
// Without it, addresses wrap modulo 2**ADDR_WIDTH and err stays 0.
module ram_burst_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 10,
   parameter int MEM_SIZE   = 256
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_WAIT = 3'd1,
      WR_DO   = 3'd2,
      RD_REQ  = 3'd3,
      RD_CAP  = 3'd4,
      RD_OUT  = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   state_t                  state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s;
   logic [ADDR_WIDTH:0]     cnt_r, cnt_nxt_s;
   logic                    wr_ready_r, wr_ready_nxt_s;
   logic                    rd_valid_r, rd_valid_nxt_s;
   logic [DATA_WIDTH-1:0]   rd_data_r, rd_data_nxt_s;
   logic                    busy_r, busy_nxt_s;
   logic                    done_r, done_nxt_s;
   logic                    err_r, err_nxt_s;
   logic                    ram_en_r, ram_en_nxt_s;
   logic                    ram_we_r, ram_we_nxt_s;
   logic [ADDR_WIDTH-1:0]   ram_addr_r, ram_addr_nxt_s;
   logic [DATA_WIDTH-1:0]   ram_din_r, ram_din_nxt_s;
   logic                    cmd_oob_s;

`ifdef RAM_BOUNDS_CHECK_EN
   // one extra bit of headroom so addr + len never overflows the compare
   localparam logic [ADDR_WIDTH+1:0] MEM_LIMIT = (ADDR_WIDTH+2)'(MEM_SIZE);
   logic [ADDR_WIDTH+1:0] end_addr_s;
   assign end_addr_s = {2'b00, cmd_addr} + {1'b0, cmd_len};
   assign cmd_oob_s  = (end_addr_s > MEM_LIMIT);
`else
   assign cmd_oob_s  = 1'b0;
`endif

   // next state, address/count bookkeeping and next values of every registered output
   always_comb begin
      state_nxt_s    = state_r;
      addr_nxt_s     = addr_r;
      cnt_nxt_s      = cnt_r;
      rd_valid_nxt_s = rd_valid_r;
      rd_data_nxt_s  = rd_data_r;
      ram_din_nxt_s  = ram_din_r;
      err_nxt_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               addr_nxt_s = cmd_addr;
               cnt_nxt_s  = cmd_len;
               if (cmd_oob_s) begin
                  state_nxt_s = DONE;
                  err_nxt_s   = 1'b1;
               end else if (cmd_len == CNT_ZERO) begin
                  state_nxt_s = DONE;
               end else if (cmd_we) begin
                  state_nxt_s = WR_WAIT;
               end else begin
                  state_nxt_s = RD_REQ;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WR_WAIT: begin
            if (wr_valid) begin
               ram_din_nxt_s = wr_data;
               state_nxt_s   = WR_DO;
            end else begin
               state_nxt_s = WR_WAIT;
            end
         end
         WR_DO: begin
            cnt_nxt_s  = cnt_r - CNT_ONE;
            addr_nxt_s = addr_r + ADDR_ONE;
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WR_WAIT;
            end
         end
         RD_REQ: begin
            state_nxt_s = RD_CAP;
         end
         RD_CAP: begin
            // RAM drives its registered word only while EN & !WE, so capture here
            rd_data_nxt_s  = ram_dout;
            rd_valid_nxt_s = 1'b1;
            state_nxt_s    = RD_OUT;
         end
         RD_OUT: begin
            if (rd_ready) begin
               rd_valid_nxt_s = 1'b0;
               cnt_nxt_s      = cnt_r - CNT_ONE;
               addr_nxt_s     = addr_r + ADDR_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RD_REQ;
               end
            end else begin
               state_nxt_s = RD_OUT;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      // outputs are registered, so they are decoded from the state being entered
      ram_en_nxt_s   = (state_nxt_s == WR_DO) || (state_nxt_s == RD_REQ) || (state_nxt_s == RD_CAP);
      ram_we_nxt_s   = (state_nxt_s == WR_DO);
      wr_ready_nxt_s = (state_nxt_s == WR_WAIT);
      busy_nxt_s     = (state_nxt_s != IDLE);
      done_nxt_s     = (state_nxt_s == DONE);
      if (ram_en_nxt_s) begin
         ram_addr_nxt_s = addr_nxt_s;
      end else begin
         ram_addr_nxt_s = ram_addr_r;
      end
   end

   // state and output registers; reset abandons any burst in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= IDLE;
         addr_r     <= ADDR_ZERO;
         cnt_r      <= CNT_ZERO;
         wr_ready_r <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= DATA_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         ram_en_r   <= 1'b0;
         ram_we_r   <= 1'b0;
         ram_addr_r <= ADDR_ZERO;
         ram_din_r  <= DATA_ZERO;
      end else begin
         state_r    <= state_nxt_s;
         addr_r     <= addr_nxt_s;
         cnt_r      <= cnt_nxt_s;
         wr_ready_r <= wr_ready_nxt_s;
         rd_valid_r <= rd_valid_nxt_s;
         rd_data_r  <= rd_data_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         err_r      <= err_nxt_s;
         ram_en_r   <= ram_en_nxt_s;
         ram_we_r   <= ram_we_nxt_s;
         ram_addr_r <= ram_addr_nxt_s;
         ram_din_r  <= ram_din_nxt_s;
      end
   end

   assign cmd_ready = (state_r == IDLE);
   assign wr_ready  = wr_ready_r;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign ram_en    = ram_en_r;
   assign ram_we    = ram_we_r;
   assign ram_addr  = ram_addr_r;
   assign ram_din   = ram_din_r;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with a behavioural single-port RAM
// and scoreboards for RAM writes and delivered read words.
module tb_ram_burst_master;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_we = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [8:0] cmd_len = 9'd0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [9:0] wr_data = 10'h000;
   logic       rd_valid;
   logic       rd_ready = 1'b1;
   logic [9:0] rd_data;
   logic       busy, done, err;
   logic       ram_en, ram_we;
   logic [7:0] ram_addr;
   logic [9:0] ram_din;
   logic [9:0] ram_dout;

   ram_burst_master #(.ADDR_WIDTH(8), .DATA_WIDTH(10), .MEM_SIZE(256)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 CLK = ~CLK;

   // behavioural RAM: registered read, output only driven while EN & !WE (0 otherwise)
   logic [9:0] mem [0:255];
   logic [9:0] dout_q;
   always @(posedge CLK) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_din;
      if (ram_en && !ram_we) dout_q <= mem[ram_addr];
   end
   assign ram_dout = (ram_en && !ram_we) ? dout_q : 10'h000;

   int total = 0;
   int bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // scoreboards and monitor bookkeeping
   logic [17:0] exp_wr_q [$];
   logic [9:0]  exp_rd_q [$];
   int          we_cyc_q [$];
   logic [9:0]  model_mem [0:255];
   logic [9:0]  wbuf [0:3];
   logic [17:0] mon_e;
   int cyc = 0;
   int ram_acc = 0, rv_cnt = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
   int acc_cnt = 0, acc_cyc = 0, first_rv = -1;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_data = 10'h000;

   always @(posedge CLK) cyc <= cyc + 1;

   // monitor samples on the falling edge, away from the active edge
   always @(negedge CLK) begin
      if (ram_en) ram_acc++;
      if (ram_en && ram_we) begin
         we_cyc_q.push_back(cyc);
         if (exp_wr_q.size() == 0) begin
            check_val("wr_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_wr_q.pop_front();
            check_val("wr_addr", 32'(ram_addr), 32'(mon_e[17:10]));
            check_val("wr_data", 32'(ram_din), 32'(mon_e[9:0]));
         end
      end
      if (rd_valid) begin
         rv_cnt++;
         if (first_rv < 0) first_rv = cyc;
      end
      if (rd_valid && rd_ready) begin
         if (exp_rd_q.size() == 0) check_val("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
         else check_val("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
      if (prev_stall) begin
         check_val("stall_valid", 32'(rd_valid), 32'd1);
         check_val("stall_data", 32'(rd_data), 32'(prev_data));
      end
      if (rd_valid && !rd_ready) check_val("stall_ram_en", 32'(ram_en), 32'd0);
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
   end

   task automatic check_idle_outs(input string tag);
      check_val(tag, 32'({wr_ready, rd_valid, busy, done, err, ram_en, ram_we, cmd_ready}), 32'h01);
      check_val(tag, 32'(rd_data), 32'd0);
      check_val(tag, 32'(ram_addr), 32'd0);
      check_val(tag, 32'(ram_din), 32'd0);
   endtask

   // present a command and hold it until accepted; returns 1 time unit after the accept edge
   task automatic issue_cmd(input logic we, input logic [7:0] a, input logic [8:0] l);
      int n = 0;
      logic ok = 1'b0;
      cmd_we = we; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
      while (!ok && n < 50) begin
         ok = cmd_ready;
         @(posedge CLK); #1;
         n++;
      end
      cmd_valid = 1'b0;
      if (!ok) check_val("cmd_timeout", 32'd0, 32'd1);
   endtask

   // stream wbuf[0..len-1] with wr_valid held high between words
   task automatic write_data(input logic [7:0] a, input int len);
      for (int i = 0; i < len; i++) begin
         int n = 0;
         logic hs = 1'b0;
         logic [7:0] wa;
         wa = a + 8'(i);
         exp_wr_q.push_back({wa, wbuf[i]});
         model_mem[wa] = wbuf[i];
         wr_valid = 1'b1; wr_data = wbuf[i];
         while (!hs && n < 50) begin
            hs = wr_ready;
            @(posedge CLK); #1;
            n++;
         end
         if (!hs) check_val("wr_timeout", 32'd0, 32'd1);
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_done();
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      check_val("done_timeout", 32'(done_cnt != start), 32'd1);
   endtask

   // read burst; word stall_idx is refused for 5 cycles after it appears
   task automatic read_burst(input logic [7:0] a, input int len, input int stall_idx);
      for (int i = 0; i < len; i++) exp_rd_q.push_back(model_mem[8'(a + 8'(i))]);
      first_rv = -1;
      issue_cmd(1'b0, a, 9'(len));
      for (int i = 0; i < len; i++) begin
         int n = 0;
         int stall_left = (i == stall_idx) ? 5 : 0;
         logic hs = 1'b0;
         while (!hs && n < 50) begin
            if (rd_valid && stall_left == 0) begin
               rd_ready = 1'b1; hs = 1'b1;
            end else if (rd_valid) begin
               rd_ready = 1'b0; stall_left--;
            end else begin
               rd_ready = (stall_left == 0);
            end
            @(posedge CLK); #1;
            n++;
         end
         if (!hs) check_val("rd_timeout", 32'd0, 32'd1);
      end
      rd_ready = 1'b1;
      wait_done();
   endtask

   initial begin
      int acc0, ram0, rv0, err0;
      // reset state
      @(negedge CLK);
      check_idle_outs("reset_outs");
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      // write burst 0x10 len 3
      wbuf[0] = 10'h3FF; wbuf[1] = 10'h001; wbuf[2] = 10'h155;
      we_cyc_q.delete();
      issue_cmd(1'b1, 8'h10, 9'd3);
      write_data(8'h10, 3);
      wait_done();
      check_val("wr_pulses", 32'(we_cyc_q.size()), 32'd3);
      if (we_cyc_q.size() == 3) begin
         check_val("wr_gap1", 32'(we_cyc_q[1] - we_cyc_q[0]), 32'd2);
         check_val("wr_gap2", 32'(we_cyc_q[2] - we_cyc_q[1]), 32'd2);
         check_val("wr_done_lat", 32'(done_cyc - we_cyc_q[2]), 32'd1);
      end

      // read back, rd_ready high
      read_burst(8'h10, 3, -1);
      check_val("rd_latency", 32'(first_rv - acc_cyc), 32'd3);

      // read with a 5-cycle stall on word 2
      read_burst(8'h10, 3, 1);
      check_val("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);

      // reset during RD_CAP of a 4-word read
      rv0 = rv_cnt;
      issue_cmd(1'b0, 8'h10, 9'd4);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      check_idle_outs("rst_in_rdcap");
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      check_val("rst_no_rdvalid", 32'(rv_cnt - rv0), 32'd0);

      // zero-length burst
      ram0 = ram_acc;
      issue_cmd(1'b1, 8'h40, 9'd0);
      wait_done();
      check_val("len0_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
      check_val("len0_no_ram", 32'(ram_acc - ram0), 32'd0);

      // command presented while busy is ignored
      acc0 = acc_cnt;
      issue_cmd(1'b1, 8'h20, 9'd1);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h30; cmd_len = 9'd2;
      for (int k = 0; k < 3; k++) begin
         check_val("busy_cmd_ready", 32'(cmd_ready), 32'd0);
         check_val("busy_flag", 32'(busy), 32'd1);
         @(posedge CLK); #1;
      end
      cmd_valid = 1'b0;
      wbuf[0] = 10'h2AA;
      write_data(8'h20, 1);
      wait_done();
      check_val("busy_one_accept", 32'(acc_cnt - acc0), 32'd1);

      // burst crossing the top of the address space
      wbuf[0] = 10'h111; wbuf[1] = 10'h222; wbuf[2] = 10'h333; wbuf[3] = 10'h044;
`ifdef RAM_BOUNDS_CHECK_EN
      ram0 = ram_acc; err0 = err_cnt;
      issue_cmd(1'b1, 8'hFE, 9'd4);
      wait_done();
      check_val("oob_err", 32'(err_cnt - err0), 32'd1);
      check_val("oob_err_with_done", 32'(err_cyc), 32'(done_cyc));
      check_val("oob_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
      check_val("oob_no_ram", 32'(ram_acc - ram0), 32'd0);
      // ending exactly at MEM_SIZE is legal
      err0 = err_cnt;
      issue_cmd(1'b1, 8'hFD, 9'd3);
      write_data(8'hFD, 3);
      wait_done();
      check_val("edge_no_err", 32'(err_cnt - err0), 32'd0);
`else
      we_cyc_q.delete();
      err0 = err_cnt;
      issue_cmd(1'b1, 8'hFE, 9'd4);
      write_data(8'hFE, 4);
      wait_done();
      check_val("wrap_pulses", 32'(we_cyc_q.size()), 32'd4);
      check_val("wrap_no_err", 32'(err_cnt - err0), 32'd0);
      read_burst(8'hFE, 4, -1);
`endif

      check_val("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
      check_val("rd_q_final", 32'(exp_rd_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
